// File: rtl/data_ram_responder_pkg.sv
// Shared definitions for the data RAM responder: FSM states, requester
// port indices and the fixed arbitration priority order.
package data_ram_responder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_ACK    = 2'd2
   } state_t;

   localparam int unsigned NUM_PORTS = 4;

   localparam int unsigned PORT_I = 0;
   localparam int unsigned PORT_S = 1;
   localparam int unsigned PORT_A = 2;
   localparam int unsigned PORT_F = 3;

   // Highest priority first.
   localparam int unsigned PRIO_ORDER [NUM_PORTS] = '{PORT_A, PORT_S, PORT_F, PORT_I};

   typedef logic [NUM_PORTS-1:0] port_vec_t;

endpackage

// File: rtl/data_ram_responder_arbiter.sv
// dram_arbiter: fixed-priority grant (A > S > F > I) for the data RAM
// responder, plus the optional atomic lock enabled by DRAM_LOCK_EN.
// Without DRAM_LOCK_EN the lock output is tied low and no state exists.
module dram_arbiter
   import data_ram_responder_pkg::*;
#(
   parameter int unsigned LOCK_TIMEOUT = 8
) (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      idle,
   input  port_vec_t req,
   input  logic      a_rd,
   input  logic      a_write_ack,
   output port_vec_t grant,
   output logic      locked
);

   port_vec_t eligible;

   // Restrict eligible requesters to the A port while the lock is held.
   always_comb begin
      eligible = req;
`ifdef DRAM_LOCK_EN
      if (locked) begin
         eligible = req & (port_vec_t'(1) << PORT_A);
      end
`endif
   end

   // Priority encoder: walk lowest to highest so the highest priority wins.
   always_comb begin
      grant = '0;
      for (int unsigned k = NUM_PORTS; k > 0; k--) begin
         if (eligible[PRIO_ORDER[k-1]]) begin
            grant = port_vec_t'(1) << PRIO_ORDER[k-1];
         end
      end
      if (!idle) begin
         grant = '0;
      end
   end

`ifdef DRAM_LOCK_EN
   localparam int unsigned CW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;

   logic [CW-1:0] idle_cnt;

   // Lock set by an A read, cleared by an A write ack or idle timeout.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         locked   <= 1'b0;
         idle_cnt <= '0;
      end else if (grant[PORT_A]) begin
         idle_cnt <= '0;
         if (a_rd) begin
            locked <= 1'b1;
         end
      end else if (a_write_ack) begin
         locked   <= 1'b0;
         idle_cnt <= '0;
      end else if (idle && locked && !req[PORT_A]) begin
         if (idle_cnt == CW'(LOCK_TIMEOUT - 1)) begin
            locked   <= 1'b0;
            idle_cnt <= '0;
         end else begin
            idle_cnt <= idle_cnt + CW'(1);
         end
      end
   end
`else
   logic unused_lock_inputs;

   assign locked             = 1'b0;
   assign unused_lock_inputs = ^{clk, rst_n, a_rd, a_write_ack};
`endif

endmodule

// File: rtl/data_ram_responder.sv
// data_ram_responder: terminates the I/S/A/F data RAM requester groups,
// arbitrates among them and owns the word-addressed data array.
// Each transaction takes IDLE -> ACCESS -> ACK; ack is a one-cycle pulse.
// Optional feature macro: DRAM_LOCK_EN (atomic read-modify-write lock).
module data_ram_responder
   import data_ram_responder_pkg::*;
#(
   parameter int unsigned DEPTH        = 256,
   parameter int unsigned LOCK_TIMEOUT = 8
) (
   input  logic        iCLK,
   input  logic        iRST,
   input  logic        iRAM_CE_I,
   input  logic        iRAM_RD_I,
   input  logic        iRAM_WR_I,
   input  logic [7:0]  iRAM_ADDR_I,
   input  logic [31:0] iRAM_DATA_WR_I,
   output logic [31:0] oRAM_DATA_RD_I,
   output logic        oRAM_ACK_I,
   input  logic        iRAM_CE_S,
   input  logic        iRAM_RD_S,
   input  logic        iRAM_WR_S,
   input  logic [7:0]  iRAM_ADDR_S,
   input  logic [31:0] iRAM_DATA_WR_S,
   output logic [31:0] oRAM_DATA_RD_S,
   output logic        oRAM_ACK_S,
   input  logic        iRAM_CE_A,
   input  logic        iRAM_RD_A,
   input  logic        iRAM_WR_A,
   input  logic [7:0]  iRAM_ADDR_A,
   input  logic [31:0] iRAM_DATA_WR_A,
   output logic [31:0] oRAM_DATA_RD_A,
   output logic        oRAM_ACK_A,
   input  logic        iRAM_CE_F,
   input  logic        iRAM_RD_F,
   input  logic        iRAM_WR_F,
   input  logic [7:0]  iRAM_ADDR_F,
   input  logic [31:0] iRAM_DATA_WR_F,
   output logic [31:0] oRAM_DATA_RD_F,
   output logic        oRAM_ACK_F,
   output logic        oBUSY
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   state_t      state;
   port_vec_t   req;
   port_vec_t   grant;
   port_vec_t   lat_grant;
   port_vec_t   ack;
   logic        lat_rd;
   logic        lat_wr;
   logic [AW-1:0] lat_idx;
   logic [31:0] lat_wdata;
   logic        locked;
   logic        a_write_ack;

   logic        in_rd    [NUM_PORTS];
   logic        in_wr    [NUM_PORTS];
   logic [7:0]  in_addr  [NUM_PORTS];
   logic [31:0] in_wdata [NUM_PORTS];

   logic        sel_rd;
   logic        sel_wr;
   logic [7:0]  sel_addr;
   logic [31:0] sel_wdata;
   logic [AW-1:0] sel_idx;

   logic [31:0] rd_data [NUM_PORTS];
   logic [31:0] mem     [DEPTH];

   // Gather the per-port request groups into indexable form.
   always_comb begin
      req              = '0;
      req[PORT_I]      = iRAM_CE_I;
      req[PORT_S]      = iRAM_CE_S;
      req[PORT_A]      = iRAM_CE_A;
      req[PORT_F]      = iRAM_CE_F;
      in_rd[PORT_I]    = iRAM_RD_I;
      in_rd[PORT_S]    = iRAM_RD_S;
      in_rd[PORT_A]    = iRAM_RD_A;
      in_rd[PORT_F]    = iRAM_RD_F;
      in_wr[PORT_I]    = iRAM_WR_I;
      in_wr[PORT_S]    = iRAM_WR_S;
      in_wr[PORT_A]    = iRAM_WR_A;
      in_wr[PORT_F]    = iRAM_WR_F;
      in_addr[PORT_I]  = iRAM_ADDR_I;
      in_addr[PORT_S]  = iRAM_ADDR_S;
      in_addr[PORT_A]  = iRAM_ADDR_A;
      in_addr[PORT_F]  = iRAM_ADDR_F;
      in_wdata[PORT_I] = iRAM_DATA_WR_I;
      in_wdata[PORT_S] = iRAM_DATA_WR_S;
      in_wdata[PORT_A] = iRAM_DATA_WR_A;
      in_wdata[PORT_F] = iRAM_DATA_WR_F;
   end

   // Select the granted port's request fields; address wraps modulo DEPTH.
   always_comb begin
      sel_rd    = 1'b0;
      sel_wr    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int unsigned k = 0; k < NUM_PORTS; k++) begin
         if (grant[k]) begin
            sel_rd    = in_rd[k];
            sel_wr    = in_wr[k];
            sel_addr  = in_addr[k];
            sel_wdata = in_wdata[k];
         end
      end
      sel_idx = AW'(32'(sel_addr) % DEPTH);
   end

   assign a_write_ack = (state == ST_ACK) && lat_grant[PORT_A] && lat_wr && !lat_rd;

   dram_arbiter #(
      .LOCK_TIMEOUT (LOCK_TIMEOUT)
   ) u_arbiter (
      .clk         (iCLK),
      .rst_n       (iRST),
      .idle        (state == ST_IDLE),
      .req         (req),
      .a_rd        (iRAM_RD_A),
      .a_write_ack (a_write_ack),
      .grant       (grant),
      .locked      (locked)
   );

   // Transaction FSM: latch in IDLE, read array in ACCESS, pulse ack in ACK.
   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         state     <= ST_IDLE;
         lat_grant <= '0;
         lat_rd    <= 1'b0;
         lat_wr    <= 1'b0;
         lat_idx   <= '0;
         lat_wdata <= '0;
         ack       <= '0;
         for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            rd_data[k] <= '0;
         end
      end else begin
         case (state)
            ST_IDLE: begin
               ack <= '0;
               if (|grant) begin
                  lat_grant <= grant;
                  lat_rd    <= sel_rd;
                  lat_wr    <= sel_wr;
                  lat_idx   <= sel_idx;
                  lat_wdata <= sel_wdata;
                  state     <= ST_ACCESS;
               end
            end
            ST_ACCESS: begin
               if (lat_rd) begin
                  for (int unsigned k = 0; k < NUM_PORTS; k++) begin
                     if (lat_grant[k]) begin
                        rd_data[k] <= mem[lat_idx];
                     end
                  end
               end
               ack   <= lat_grant;
               state <= ST_ACK;
            end
            ST_ACK: begin
               ack   <= '0;
               state <= ST_IDLE;
            end
            default: begin
               ack   <= '0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Array write; reset forces IDLE, so an interrupted write never commits.
   always_ff @(posedge iCLK) begin
      if (state == ST_ACCESS && lat_wr && !lat_rd) begin
         mem[lat_idx] <= lat_wdata;
      end
   end

   assign oBUSY = (state != ST_IDLE) | locked;

   assign oRAM_ACK_I     = ack[PORT_I];
   assign oRAM_ACK_S     = ack[PORT_S];
   assign oRAM_ACK_A     = ack[PORT_A];
   assign oRAM_ACK_F     = ack[PORT_F];
   assign oRAM_DATA_RD_I = rd_data[PORT_I];
   assign oRAM_DATA_RD_S = rd_data[PORT_S];
   assign oRAM_DATA_RD_A = rd_data[PORT_A];
   assign oRAM_DATA_RD_F = rd_data[PORT_F];

endmodule

// File: tb/tb_data_ram_responder.sv
// Self-checking bench for data_ram_responder: a transaction-level model
// pushes expected acks (port, cycle, read data) into a queue; a negedge
// monitor pops and compares whenever any ack is seen.
// Lock scenarios are compiled in when DRAM_LOCK_EN is defined.
module tb_data_ram_responder;

   localparam int DEPTH = 64;
   localparam int LT    = 8;
   localparam int P_I = 0, P_S = 1, P_A = 2, P_F = 3;

   typedef struct {
      int          port;
      bit          is_read;
      logic [31:0] data;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ce [4];
   logic        rd [4];
   logic        wr [4];
   logic [7:0]  addr [4];
   logic [31:0] wdata [4];
   logic [31:0] d_i, d_s, d_a, d_f;
   logic        a_i, a_s, a_a, a_f;
   logic        busy;

   exp_t        exp_q [$];
   logic [31:0] mem_m [DEPTH];
   logic [31:0] rd_m [4];
   int          tests = 0;
   int          fails = 0;
   int          cyc = 0;

   data_ram_responder #(
      .DEPTH        (DEPTH),
      .LOCK_TIMEOUT (LT)
   ) dut (
      .iCLK           (clk),
      .iRST           (rst_n),
      .iRAM_CE_I      (ce[0]),
      .iRAM_RD_I      (rd[0]),
      .iRAM_WR_I      (wr[0]),
      .iRAM_ADDR_I    (addr[0]),
      .iRAM_DATA_WR_I (wdata[0]),
      .oRAM_DATA_RD_I (d_i),
      .oRAM_ACK_I     (a_i),
      .iRAM_CE_S      (ce[1]),
      .iRAM_RD_S      (rd[1]),
      .iRAM_WR_S      (wr[1]),
      .iRAM_ADDR_S    (addr[1]),
      .iRAM_DATA_WR_S (wdata[1]),
      .oRAM_DATA_RD_S (d_s),
      .oRAM_ACK_S     (a_s),
      .iRAM_CE_A      (ce[2]),
      .iRAM_RD_A      (rd[2]),
      .iRAM_WR_A      (wr[2]),
      .iRAM_ADDR_A    (addr[2]),
      .iRAM_DATA_WR_A (wdata[2]),
      .oRAM_DATA_RD_A (d_a),
      .oRAM_ACK_A     (a_a),
      .iRAM_CE_F      (ce[3]),
      .iRAM_RD_F      (rd[3]),
      .iRAM_WR_F      (wr[3]),
      .iRAM_ADDR_F    (addr[3]),
      .iRAM_DATA_WR_F (wdata[3]),
      .oRAM_DATA_RD_F (d_f),
      .oRAM_ACK_F     (a_f),
      .oBUSY          (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] dout(input int p);
      case (p)
         0:       return d_i;
         1:       return d_s;
         2:       return d_a;
         default: return d_f;
      endcase
   endfunction

   function automatic logic ackv(input int p);
      case (p)
         0:       return a_i;
         1:       return a_s;
         2:       return a_a;
         default: return a_f;
      endcase
   endfunction

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, req, cyc);
      end
   endfunction

   // Reference: a write with RD=0 updates memory; any RD=1 returns stored word.
   function automatic void expect_txn(input int p, input bit r, input bit w,
                                      input logic [7:0] a, input logic [31:0] d, input int ack_cyc);
      exp_t e;
      int   idx;
      idx       = int'(a) % DEPTH;
      e.port    = p;
      e.is_read = r;
      e.cyc     = ack_cyc;
      e.data    = '0;
      if (r) e.data = mem_m[idx];
      else if (w) mem_m[idx] = d;
      exp_q.push_back(e);
   endfunction

   task automatic drive(input int p, input bit r, input bit w, input logic [7:0] a, input logic [31:0] d);
      ce[p]    = 1'b1;
      rd[p]    = r;
      wr[p]    = w;
      addr[p]  = a;
      wdata[p] = d;
   endtask

   task automatic drain(input int budget);
      int  n;
      bit  any;
      n = 0;
      while (1) begin
         @(negedge clk);
         for (int p = 0; p < 4; p++) if (ackv(p)) ce[p] = 1'b0;
         any = 1'b0;
         for (int p = 0; p < 4; p++) if (ce[p]) any = 1'b1;
         if (!any && exp_q.size() == 0) break;
         n++;
         if (n > budget) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: %0d acks still outstanding after %0d cycles", exp_q.size(), budget);
            for (int p = 0; p < 4; p++) ce[p] = 1'b0;
            exp_q.delete();
            break;
         end
      end
      @(negedge clk);
   endtask

   task automatic txn(input int p, input bit r, input bit w, input logic [7:0] a, input logic [31:0] d);
      drive(p, r, w, a, d);
      expect_txn(p, r, w, a, d, cyc + 2);
      drain(40);
   endtask

   // Monitor: every ack is matched against the head of the expectation queue.
   always @(negedge clk) begin
      exp_t e;
      int   nack;
      if (!rst_n) begin
         for (int q = 0; q < 4; q++) rd_m[q] = '0;
      end else begin
         nack = 0;
         for (int p = 0; p < 4; p++) begin
            if (ackv(p)) begin
               nack++;
               if (exp_q.size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL unexpected_ack: port %0d acked with nothing outstanding (cycle %0d)", p, cyc);
               end else begin
                  e = exp_q.pop_front();
                  chk("ack_port", 32'(p), 32'(e.port));
                  chk("ack_cycle", 32'(cyc), 32'(e.cyc));
                  if (e.is_read) begin
                     chk("rd_data", dout(p), e.data);
                     rd_m[p] = e.data;
                  end
                  for (int q = 0; q < 4; q++) chk("data_hold", dout(q), rd_m[q]);
               end
            end
         end
         if (nack > 1) begin
            tests++;
            fails++;
            $display("FAIL multi_ack: %0d acks in one cycle, expected at most 1", nack);
         end
         while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            tests++;
            fails++;
            $display("FAIL ack_missing: port %0d got no ack, expected at cycle %0d", e.port, e.cyc);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int   c, k, mask, op;
      bit   r, w;
      int   order [4];
      logic [7:0] a;

      order = '{P_A, P_S, P_F, P_I};
      for (int p = 0; p < 4; p++) begin
         ce[p] = 1'b0; rd[p] = 1'b0; wr[p] = 1'b0; addr[p] = '0; wdata[p] = '0;
      end

      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      for (int p = 0; p < 4; p++) begin
         chk("reset_ack", 32'(ackv(p)), 32'd0);
         chk("reset_data", dout(p), 32'd0);
      end
      chk("reset_busy", 32'(busy), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Known contents everywhere, written through every port.
      for (int i = 0; i < DEPTH; i++) txn(i % 4, 1'b0, 1'b1, 8'(i), $urandom);
      chk("idle_busy", 32'(busy), 32'd0);

      // Write then read across ports; then an aliased address wraps onto 0x10.
      txn(P_S, 1'b0, 1'b1, 8'h10, 32'hDEADBEEF);
      txn(P_I, 1'b1, 1'b0, 8'h10, 32'h0);
      txn(P_F, 1'b0, 1'b1, 8'(8'h10 + DEPTH), 32'hCAFEF00D);
      txn(P_I, 1'b1, 1'b0, 8'h10, 32'h0);
      txn(P_S, 1'b1, 1'b0, 8'hFF, 32'h0);

      // Degenerate requests.
      txn(P_S, 1'b0, 1'b0, 8'h11, 32'hFFFFFFFF);
      txn(P_F, 1'b1, 1'b0, 8'h11, 32'h0);
      txn(P_S, 1'b1, 1'b1, 8'h12, 32'h00001234);
      txn(P_I, 1'b1, 1'b0, 8'h12, 32'h0);

      // Four-way contention: served A, S, F, I, three cycles apart.
      c = cyc;
      drive(P_A, 1'b0, 1'b1, 8'h13, 32'hA0A0A0A0);
      drive(P_S, 1'b0, 1'b1, 8'h13, 32'h5151_5151);
      drive(P_F, 1'b1, 1'b0, 8'h13, 32'h0);
      drive(P_I, 1'b0, 1'b1, 8'h14, 32'h1111_2222);
      expect_txn(P_A, 1'b0, 1'b1, 8'h13, 32'hA0A0A0A0, c + 2);
      expect_txn(P_S, 1'b0, 1'b1, 8'h13, 32'h5151_5151, c + 5);
      expect_txn(P_F, 1'b1, 1'b0, 8'h13, 32'h0, c + 8);
      expect_txn(P_I, 1'b0, 1'b1, 8'h14, 32'h1111_2222, c + 11);
      drain(60);

      // Reset during the ACCESS cycle of a write aborts it.
      txn(P_S, 1'b0, 1'b1, 8'h20, 32'h5);
      drive(P_S, 1'b0, 1'b1, 8'h20, 32'h77);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      for (int p = 0; p < 4; p++) begin
         chk("midreset_ack", 32'(ackv(p)), 32'd0);
         chk("midreset_data", dout(p), 32'd0);
      end
      chk("midreset_busy", 32'(busy), 32'd0);
      @(negedge clk);
      ce[P_S] = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      txn(P_I, 1'b1, 1'b0, 8'h20, 32'h0);

      // Random bursts of simultaneous requests, served in priority order.
      for (int it = 0; it < 120; it++) begin
         mask = $urandom_range(1, 15);
         c = cyc;
         k = 0;
         for (int j = 0; j < 4; j++) begin
            if (mask[order[j]]) begin
               op = $urandom_range(0, 9);
               r  = (op >= 4 && op <= 8);
               w  = (op <= 3 || op == 8);
`ifdef DRAM_LOCK_EN
               if (order[j] == P_A) begin r = 1'b0; w = 1'b1; end
`endif
               a = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
               drive(order[j], r, w, a, $urandom);
               expect_txn(order[j], r, w, a, wdata[order[j]], c + 2 + 3 * k);
               k++;
            end
         end
         drain(60);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

`ifdef DRAM_LOCK_EN
      // A read locks out S until the A write to the same address completes.
      txn(P_A, 1'b1, 1'b0, 8'h30, 32'h0);
      chk("lock_busy", 32'(busy), 32'd1);
      drive(P_S, 1'b0, 1'b1, 8'h31, 32'hABCD0001);
      repeat (3) @(negedge clk);
      chk("lock_hold_busy", 32'(busy), 32'd1);
      c = cyc;
      drive(P_A, 1'b0, 1'b1, 8'h30, 32'h600DF00D);
      expect_txn(P_A, 1'b0, 1'b1, 8'h30, 32'h600DF00D, c + 2);
      expect_txn(P_S, 1'b0, 1'b1, 8'h31, 32'hABCD0001, c + 5);
      drain(60);
      chk("unlock_busy", 32'(busy), 32'd0);

      // A read then silence: the lock times out and the pending I read is served.
      c = cyc;
      drive(P_A, 1'b1, 1'b0, 8'h30, 32'h0);
      drive(P_I, 1'b1, 1'b0, 8'h31, 32'h0);
      expect_txn(P_A, 1'b1, 1'b0, 8'h30, 32'h0, c + 2);
      expect_txn(P_I, 1'b1, 1'b0, 8'h31, 32'h0, c + 2 + 3 + LT);
      drain(60);
      chk("timeout_busy", 32'(busy), 32'd0);
`endif

      repeat (3) @(negedge clk);
      chk("queue_empty", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
